// File: rtl/exc_vector_ctrl.sv
// Exception vector sequencer: saves EPC, fetches the vector byte (253/254/255) and reloads PC.
// Latency: exception cycle to pc_we is 2 + MEM_LAT cycles; done follows one cycle later.
// Backpressure: none; exceptions raised outside IDLE are dropped. Optional EXC_CAUSE_EN exposes exc_cause.
module exc_vector_ctrl #(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    output logic [2:0]  iord_sel,
    output logic        mem_rd,
    output logic        epc_we,
    output logic [31:0] epc,
    output logic        pc_we,
    output logic [31:0] pc_out,
    output logic        exc_active,
`ifdef EXC_CAUSE_EN
    output logic [1:0]  exc_cause,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [1:0]  cause_q;
    logic [31:0] epc_q;
    logic [31:0] pc_q;
    logic        any_exc;
    logic        take_exc;
    logic [1:0]  cause_d;

    // Only the vector byte of the memory word is meaningful here.
    logic unused_mem_hi;
    assign unused_mem_hi = ^mem_data[31:8];

    assign any_exc  = exc_opcode | exc_ovf | exc_div0;
    assign take_exc = (state_q == S_IDLE) && any_exc;
    // Cause codes 01/10/11 map directly onto vector bytes 253/254/255.
    assign cause_d  = exc_opcode ? 2'b01 : (exc_ovf ? 2'b10 : 2'b11);

    // State register and memory-latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ADDR) begin
                cnt_q <= LAT_M1;
            end else if ((state_q == S_WAIT) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Captured exception context: cause and EPC on acceptance, new PC at the end of LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q <= 2'b00;
            epc_q   <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            if (take_exc) begin
                cause_q <= cause_d;
                epc_q   <= pc_in - EPC_OFFSET;
            end
            if (state_q == S_LOAD) begin
                pc_q <= {24'd0, mem_data[7:0]};
            end
        end
    end

    // Next-state and Moore outputs; pc_out shows the fetched byte in the same cycle as pc_we.
    always_comb begin
        state_d    = state_q;
        iord_sel   = 3'b000;
        mem_rd     = 1'b0;
        pc_we      = 1'b0;
        exc_active = 1'b0;
        done       = 1'b0;
        pc_out     = pc_q;
        epc_we     = take_exc && reset;
        case (state_q)
            S_IDLE: begin
                if (any_exc) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                exc_active = 1'b1;
                iord_sel   = {1'b0, cause_q} + 3'd1;
                mem_rd     = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                exc_active = 1'b1;
                iord_sel   = {1'b0, cause_q} + 3'd1;
                mem_rd     = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                exc_active = 1'b1;
                pc_we      = 1'b1;
                pc_out     = {24'd0, mem_data[7:0]};
                state_d    = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign epc = epc_q;
`ifdef EXC_CAUSE_EN
    assign exc_cause = cause_q;
`endif

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Bench for exc_vector_ctrl: two instances (MEM_LAT 1 and 3) share stimulus.
// Expected outputs come from a timeline model keyed on cycles since the accepted exception.
// Directed cases first, then randomized exception pulses, PCs and memory data.
module tb_exc_vector_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_ovf = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_data = 32'd0;

    logic [2:0]  iord_sel   [2];
    logic        mem_rd     [2];
    logic        epc_we     [2];
    logic [31:0] epc        [2];
    logic        pc_we      [2];
    logic [31:0] pc_out     [2];
    logic        exc_active [2];
    logic        done       [2];
`ifdef EXC_CAUSE_EN
    logic [1:0]  exc_cause  [2];
`endif

    int total = 0;
    int bad = 0;

    // model state per instance: t = cycles since acceptance (-1 = idle)
    int          t       [2];
    int          m_addr  [2];
    logic [31:0] m_epc   [2];
    logic [31:0] m_pc    [2];
    logic [1:0]  m_cause [2];

    always #5 clk = ~clk;

    exc_vector_ctrl #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data(mem_data),
        .iord_sel(iord_sel[0]), .mem_rd(mem_rd[0]), .epc_we(epc_we[0]), .epc(epc[0]),
        .pc_we(pc_we[0]), .pc_out(pc_out[0]), .exc_active(exc_active[0]),
`ifdef EXC_CAUSE_EN
        .exc_cause(exc_cause[0]),
`endif
        .done(done[0])
    );

    exc_vector_ctrl #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data(mem_data),
        .iord_sel(iord_sel[1]), .mem_rd(mem_rd[1]), .epc_we(epc_we[1]), .epc(epc[1]),
        .pc_we(pc_we[1]), .pc_out(pc_out[1]), .exc_active(exc_active[1]),
`ifdef EXC_CAUSE_EN
        .exc_cause(exc_cause[1]),
`endif
        .done(done[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t[i] = -1;
            m_addr[i] = 0;
            m_epc[i] = 32'd0;
            m_pc[i] = 32'd0;
            m_cause[i] = 2'b00;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_d%0d_sel", tag, i), 32'(iord_sel[i]), 32'd0);
            chk($sformatf("%s_d%0d_rd", tag, i), 32'(mem_rd[i]), 32'd0);
            chk($sformatf("%s_d%0d_epcwe", tag, i), 32'(epc_we[i]), 32'd0);
            chk($sformatf("%s_d%0d_epc", tag, i), epc[i], 32'd0);
            chk($sformatf("%s_d%0d_pcwe", tag, i), 32'(pc_we[i]), 32'd0);
            chk($sformatf("%s_d%0d_pc", tag, i), pc_out[i], 32'd0);
            chk($sformatf("%s_d%0d_act", tag, i), 32'(exc_active[i]), 32'd0);
            chk($sformatf("%s_d%0d_done", tag, i), 32'(done[i]), 32'd0);
`ifdef EXC_CAUSE_EN
            chk($sformatf("%s_d%0d_cause", tag, i), 32'(exc_cause[i]), 32'd0);
`endif
        end
    endtask

    // compare this cycle's outputs with the timeline, then advance the model
    task automatic check_cycle();
        logic        any;
        int          l;
        logic        e_rd;
        logic        e_pcwe;
        logic [31:0] e_pc;
        any = exc_opcode | exc_ovf | exc_div0;
        for (int i = 0; i < 2; i++) begin
            l = lat_of(i);
            e_rd = (t[i] >= 1) && (t[i] <= 1 + l);
            e_pcwe = (t[i] == 2 + l);
            e_pc = e_pcwe ? {24'd0, mem_data[7:0]} : m_pc[i];
            chk($sformatf("d%0d_epcwe", i), 32'(epc_we[i]), 32'((t[i] < 0) && any));
            chk($sformatf("d%0d_rd", i), 32'(mem_rd[i]), 32'(e_rd));
            chk($sformatf("d%0d_sel", i), 32'(iord_sel[i]), e_rd ? 32'(m_addr[i] - 251) : 32'd0);
            chk($sformatf("d%0d_act", i), 32'(exc_active[i]), 32'((t[i] >= 1) && (t[i] <= 2 + l)));
            chk($sformatf("d%0d_pcwe", i), 32'(pc_we[i]), 32'(e_pcwe));
            chk($sformatf("d%0d_done", i), 32'(done[i]), 32'(t[i] == 3 + l));
            chk($sformatf("d%0d_epc", i), epc[i], m_epc[i]);
            if (e_pcwe || t[i] < 0 || t[i] > 2 + l)
                chk($sformatf("d%0d_pc", i), pc_out[i], e_pc);
`ifdef EXC_CAUSE_EN
            chk($sformatf("d%0d_cause", i), 32'(exc_cause[i]), 32'(m_cause[i]));
`endif
            if (t[i] < 0) begin
                if (any) begin
                    t[i] = 1;
                    m_addr[i] = exc_opcode ? 253 : (exc_ovf ? 254 : 255);
                    m_epc[i] = pc_in - 32'd4;
                    m_cause[i] = 2'(m_addr[i] - 252);
                end
            end else begin
                if (e_pcwe) m_pc[i] = e_pc;
                t[i] = t[i] + 1;
                if (t[i] > 3 + l) t[i] = -1;
            end
        end
    endtask

    task automatic cycle(input logic o, input logic v, input logic d,
                         input logic [31:0] pc, input logic [31:0] md);
        @(posedge clk);
        #1;
        exc_opcode = o;
        exc_ovf = v;
        exc_div0 = d;
        pc_in = pc;
        mem_data = md;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n, input logic [31:0] md);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, $urandom, md);
    endtask

    initial begin
        logic [2:0]  r;
        logic [31:0] pcv;
        model_reset();
        #1;
        check_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // invalid opcode, vector 253, PC 0x40
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_00A5);
        idle(8, 32'h0000_00A5);
        chk("opc_epc", epc[0], 32'h0000_003C);
        chk("opc_pc", pc_out[0], 32'h0000_00A5);

        // overflow and div0 together: overflow wins
        cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BE77);
        idle(8, 32'hDEAD_BE77);
        chk("ovf_epc", epc[1], 32'h1234_5674);

        // div0 with PC 0 wraps EPC; only the low byte of memory reaches PC
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FF12);
        idle(8, 32'hFFFF_FF12);
        chk("div0_epc", epc[0], 32'hFFFF_FFFC);
        chk("div0_pc", pc_out[1], 32'h0000_0012);

        // opcode pulse during WAIT is ignored
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0033);
        cycle(1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0033);
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0033);
        idle(7, 32'h0000_0033);
        chk("ign_epc", epc[1], 32'h0000_0FFC);

        // reset mid-WAIT on the MEM_LAT=3 instance, then a clean restart
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_0044);
        idle(2, 32'h0000_0044);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("rsthold");
        reset = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_0055);
        idle(8, 32'h0000_0055);
        chk("rst_epc", epc[0], 32'h0000_5FFC);
        chk("rst_pc", pc_out[1], 32'h0000_0055);

        // randomized pulses, PCs and memory data
        for (int k = 0; k < 2000; k++) begin
            r = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            pcv = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            cycle(r[2], r[1], r[0], pcv, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_vector_ctrl.md
Name: exc_vector_ctrl

Overview:
- Exception sequencer for the multicycle MIPS datapath; sits directly upstream of the memory-address selector and drives its 3-bit select during exception handling.
- On an exception pulse it saves EPC, drives the select to the matching vector-byte address (253/254/255), waits out the memory latency, then loads PC with the zero-extended vector byte.
- The main control unit yields the address select and PC write to this block while exc_active is high.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address to valid mem_data (legal 1..7).
- EPC_OFFSET, 4, value subtracted from pc_in to form EPC (PC is already incremented when the exception is raised).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- exc_opcode  input  1  invalid-opcode exception pulse.
- exc_ovf  input  1  arithmetic overflow exception pulse.
- exc_div0  input  1  divide-by-zero exception pulse.
- pc_in  input  32  current PC value.
- mem_data  input  32  memory read data; vector in bits [7:0].
- iord_sel  output  3  address-select code: 010=253, 011=254, 100=255; 000 when idle.
- mem_rd  output  1  memory read strobe.
- epc_we  output  1  EPC write enable.
- epc  output  32  saved exception PC.
- pc_we  output  1  PC write enable.
- pc_out  output  32  new PC = {24'b0, mem_data[7:0]}.
- exc_active  output  1  block owns address select and PC write.
- done  output  1  one-cycle pulse when handling completes.

Behaviour:
- Reset (async, reset low): state IDLE; iord_sel=000, mem_rd=0, epc_we=0, epc=0, pc_we=0, pc_out=0, exc_active=0, done=0, wait counter=0.
- States: IDLE, ADDR, WAIT, LOAD, DONE.
- IDLE: sample exceptions each cycle. If any is high, latch the cause with priority exc_opcode > exc_ovf > exc_div0, register epc <= pc_in - EPC_OFFSET (32-bit modulo), pulse epc_we for that cycle, then go to ADDR.
- ADDR: exc_active=1; iord_sel = cause code; mem_rd=1; load counter with MEM_LAT-1; go to WAIT.
- WAIT: iord_sel held; mem_rd=1; if counter==0 go to LOAD, else decrement. With MEM_LAT=1, WAIT lasts exactly one cycle.
- LOAD: pc_out <= {24'b0, mem_data[7:0]}; pc_we=1 for exactly this cycle; mem_rd=0; go to DONE.
- DONE: done=1 for one cycle; exc_active=0 from the next cycle; iord_sel returns to 000; return to IDLE.
- Latency: exception-raised cycle to pc_we = 2 + MEM_LAT cycles.
- Exception inputs are ignored in every state except IDLE; there is no queueing.
- Simultaneous exceptions: only the highest-priority one is handled; the others are dropped.
- exc_active is high in ADDR, WAIT and LOAD.
- epc holds its value until the next exception or reset.
- Reset asserted mid-sequence aborts immediately to the reset values; no partial pc_we.
- pc_in == 0 at exception: epc = 0xFFFFFFFC (wrap).

Optional Feature:
- EXC_CAUSE_EN. When defined: adds output exc_cause[1:0] (01=opcode, 10=overflow, 11=div0, 00=none), registered in the IDLE->ADDR transition, held until the next exception, reset to 00.
- When not defined: the port is absent and the cause is internal only.

Test Plan:
- reset low mid-WAIT -> all outputs zero on the same edge, state IDLE; after release, exc_ovf pulse -> sequence restarts normally.
- pc_in=0x00000040, exc_opcode pulse, MEM_LAT=1, mem_data=0x000000A5 -> epc=0x0000003C, iord_sel=010 for 2 cycles, pc_we pulse with pc_out=0x000000A5 three cycles after the pulse, then done.
- exc_ovf and exc_div0 raised in the same cycle -> iord_sel=011 only; the div0 exception is dropped; exc_cause=10 if EXC_CAUSE_EN.
- MEM_LAT=3, exc_div0 -> iord_sel=100 and mem_rd high for 4 cycles; pc_we 5 cycles after the pulse.
- exc_opcode pulse while in WAIT -> ignored, epc unchanged, one pc_we total.
- pc_in=0x00000000, exc_div0 -> epc=0xFFFFFFFC; mem_data=0xFFFFFF12 -> pc_out=0x00000012.
